fetch_pc_unit: RTL

- PC-generation and IF/ID staging block directly upstream of instruction_fetch.
- Holds the architectural PC and drives it to the fetch stage.
- Takes back the fetched instruction and the invAddr flag, and registers {instruction, PC, valid} for decode.
- Handles stall, branch redirect/flush, halt-sentinel detection and the invalid-address fault.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/if_id_reg.sv | 68 ++++++
 rtl/fetch_pc_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the front end of the core:
//   - XLEN / ILEN      : address and instruction widths
//   - RESET_PC_DEF     : default PC loaded by reset
//   - HALT_INSTR_DEF   : default sentinel word that stops fetch
//   - PC_STEP_DEF      : default sequential PC increment
//   - state_e          : fetch state machine encoding (RUN, HALT, FAULT)
//   - is_sentinel()    : helper comparing a fetched word against the sentinel
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 64'h0000_0000_0000_0000;
    localparam logic [ILEN-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] PC_STEP_DEF    = 64'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // True when the fetched word matches the halt sentinel.
    function automatic logic is_sentinel(input logic [ILEN-1:0] word,
                                         input logic [ILEN-1:0] sentinel);
        return (word == sentinel);
    endfunction

endpackage : cpu_pkg

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register holding {valid, instruction, pc} for decode.
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset (clears all fields)
//   load      : capture instr_in/pc_in and mark the entry valid
//   flush     : invalidate the entry; instr/pc keep their last values
//   instr_in  : instruction word to capture
//   pc_in     : PC of that instruction
//   valid     : entry is live
//   instr     : latched instruction
//   pc        : latched PC
// With neither load nor flush the register holds. Flush wins over load.
// -----------------------------------------------------------------------------
module if_id_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [ILEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    logic            valid_d, valid_q;
    logic [ILEN-1:0] instr_d, instr_q;
    logic [XLEN-1:0] pc_d,    pc_q;

    // Next-state selection: flush, load or hold.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            // Only the valid bit drops; payload is retained so decode sees stable data.
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0000_0000;
            pc_q    <= 64'h0000_0000_0000_0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule : if_id_reg

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// PC generation and IF/ID staging directly upstream of instruction_fetch.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   stall          : freeze PC and IF/ID
//   branch_taken   : redirect request from execute
//   branch_target  : redirect address
//   instruction    : word fetched combinationally for the current pc
//   inv_addr       : fetch reported an invalid address for the current pc
//   pc             : current PC driven to instruction_fetch
//   if_instr/if_pc/if_valid : IF/ID register contents for decode
//   halted         : HALT state indicator
//   fault          : FAULT state indicator
//   fault_pc       : PC that raised the fault
// RUN priority per edge: branch > stall > inv_addr > halt sentinel > advance.
// HALT and FAULT are terminal until reset; branch and stall are ignored there.
// -----------------------------------------------------------------------------
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [ILEN-1:0] HALT_INSTR = HALT_INSTR_DEF,
    parameter logic [XLEN-1:0] PC_STEP    = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [ILEN-1:0] instruction,
    input  logic            inv_addr,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_valid,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    state_e          state_d,    state_q;
    logic [XLEN-1:0] pc_d,       pc_q;
    logic            halted_d,   halted_q;
    logic            fault_d,    fault_q;
    logic [XLEN-1:0] fault_pc_d, fault_pc_q;
    logic            ifid_load_s;
    logic            ifid_flush_s;

    // Next-state, next-PC and IF/ID control decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        halted_d     = halted_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        ifid_load_s  = 1'b0;
        ifid_flush_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect beats everything, including a fault or sentinel on
                    // the wrong-path word. A misaligned target faults next cycle.
                    pc_d         = branch_target;
                    ifid_flush_s = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (inv_addr) begin
                    // Checked before the sentinel so an X word is never examined or captured.
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_pc_d   = pc_q;
                    ifid_flush_s = 1'b1;
                end else if (is_sentinel(instruction, HALT_INSTR)) begin
                    state_d      = ST_HALT;
                    halted_d     = 1'b1;
                    ifid_flush_s = 1'b1;
                end else begin
                    // Modulo 2^64: the wrap to zero is intentional and silent.
                    pc_d        = pc_q + PC_STEP;
                    ifid_load_s = 1'b1;
                end
            end
            ST_HALT, ST_FAULT: begin
                // Terminal: keep the IF/ID entry dead, everything else frozen.
                ifid_flush_s = 1'b1;
            end
            default: begin
                // Unreachable encoding: park in FAULT so the core stops safely.
                state_d      = ST_FAULT;
                fault_d      = 1'b1;
                fault_pc_d   = pc_q;
                ifid_flush_s = 1'b1;
            end
        endcase
    end

    // State machine and architectural PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 64'h0000_0000_0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load_s),
        .flush    (ifid_flush_s),
        .instr_in (instruction),
        .pc_in    (pc_q),
        .valid    (if_valid),
        .instr    (if_instr),
        .pc       (if_pc)
    );

    assign pc       = pc_q;
    assign halted   = halted_q;
    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;

endmodule : fetch_pc_unit
